// File: rtl/alu_writeback_buffer.sv
// In-order writeback queue between the ALU and the register-file write port.
// Retires results under valid/ready, updates architectural flags, and serves operand forwarding.
module alu_writeback_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [DATA_W-1:0]          res_data,
  input  logic [ADDR_W-1:0]          res_dest,
  input  logic                       res_wen,
  input  logic                       res_carry,
  input  logic                       res_zero,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_data,
  output logic [ADDR_W-1:0]          wb_dest,
  output logic                       wb_wen,
  output logic                       carry_flag,
  output logic                       zero_flag,
  input  logic [ADDR_W-1:0]          fwd_addr1,
  output logic                       fwd_hit1,
  output logic [DATA_W-1:0]          fwd_data1,
  input  logic [ADDR_W-1:0]          fwd_addr2,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NPORT = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dest;
    logic              wen;
    logic              carry;
    logic              zero;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             wr_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               push;
  logic               pop;

  assign res_ready = (count_q < CNT_W'(DEPTH));
  assign wb_valid  = (count_q != '0);
  assign push      = res_valid && res_ready;
  assign pop       = wb_valid && wb_ready;
  assign count     = count_q;

  assign wr_entry.data  = res_data;
  assign wr_entry.dest  = res_dest;
  assign wr_entry.wen   = res_wen;
  assign wr_entry.carry = res_carry;
  assign wr_entry.zero  = res_zero;

  assign head    = mem[rd_ptr];
  assign wb_data = head.data;
  assign wb_dest = head.dest;
  assign wb_wen  = head.wen;

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        carry_flag <= head.carry;
        zero_flag  <= head.zero;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entries viewed oldest-first so the last match in the scan is the youngest.
  entry_t                          age_ent [DEPTH];
  logic [DEPTH-1:0]                age_vld;
  logic [NPORT-1:0][ADDR_W-1:0]    fwd_addr;
  logic [NPORT-1:0]                fwd_hit;
  logic [NPORT-1:0][DATA_W-1:0]    fwd_data;

  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      age_ent[a] = mem[rd_ptr + PTR_W'(a)];
      age_vld[a] = (CNT_W'(a) < count_q);
    end
  end

  assign fwd_addr[0] = fwd_addr1;
  assign fwd_addr[1] = fwd_addr2;

  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < NPORT; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (age_vld[a] && age_ent[a].wen && (age_ent[a].dest == fwd_addr[p])) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = age_ent[a].data;
        end
      end
    end
  end

  assign fwd_hit1  = fwd_hit[0];
  assign fwd_data1 = fwd_data[0];
  assign fwd_hit2  = fwd_hit[1];
  assign fwd_data2 = fwd_data[1];

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Directed bench with a scoreboard queue; a negedge monitor models occupancy, retire order and flags.
module tb_alu_writeback_buffer;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              res_valid, res_ready;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_dest;
  logic              res_wen, res_carry, res_zero;
  logic              wb_valid, wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_dest;
  logic              wb_wen, carry_flag, zero_flag;
  logic [ADDR_W-1:0] fwd_addr1, fwd_addr2;
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
  logic [1:0]        count;

  alu_writeback_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_dest(res_dest),
    .res_wen(res_wen), .res_carry(res_carry), .res_zero(res_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest), .wb_wen(wb_wen),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .fwd_addr1(fwd_addr1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_addr2(fwd_addr2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic w, c, z;
  } ent_t;

  ent_t sb[$];
  logic m_carry = 1'b0;
  logic m_zero  = 1'b0;
  int   total   = 0;
  int   passed  = 0;
  int   retired = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Model decisions come from the scoreboard, not from the DUT handshake outputs.
  always @(negedge clk) begin
    if (!reset) begin
      logic exp_ready, exp_valid;
      ent_t e;
      exp_ready = (sb.size() < DEPTH);
      exp_valid = (sb.size() > 0);
      chk("mon_count", 32'(count), 32'(sb.size()));
      chk("mon_res_ready", 32'(res_ready), 32'(exp_ready));
      chk("mon_wb_valid", 32'(wb_valid), 32'(exp_valid));
      chk("mon_carry", 32'(carry_flag), 32'(m_carry));
      chk("mon_zero", 32'(zero_flag), 32'(m_zero));
      if (exp_valid && wb_ready) begin
        e = sb.pop_front();
        chk("ret_data", 32'(wb_data), 32'(e.d));
        chk("ret_dest", 32'(wb_dest), 32'(e.a));
        chk("ret_wen", 32'(wb_wen), 32'(e.w));
        m_carry = e.c;
        m_zero  = e.z;
        retired++;
      end
      if (res_valid && exp_ready) begin
        e.d = res_data; e.a = res_dest; e.w = res_wen; e.c = res_carry; e.z = res_zero;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [2:0] a, input logic w, input logic c,
                       input logic z);
    res_valid = 1'b1; res_data = d; res_dest = a; res_wen = w; res_carry = c; res_zero = z;
  endtask

  initial begin
    reset = 1'b1; res_valid = 1'b0; res_data = '0; res_dest = '0; res_wen = 1'b0;
    res_carry = 1'b0; res_zero = 1'b0; wb_ready = 1'b0; fwd_addr1 = '0; fwd_addr2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and idle forwarding
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd1);
    chk("rst_carry", 32'(carry_flag), 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    for (int i = 0; i < 8; i++) begin
      fwd_addr1 = 3'(i); fwd_addr2 = 3'(i);
      #1;
      chk("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
      chk("rst_fwd_hit2", 32'(fwd_hit2), 32'd0);
    end

    // Single push, 1-cycle latency, retire loads flags
    step();
    wb_ready = 1'b1;
    drive(8'h5A, 3'd3, 1'b1, 1'b1, 1'b0);
    step();
    res_valid = 1'b0;
    chk("lat_wb_valid", 32'(wb_valid), 32'd1);
    chk("lat_wb_data", 32'(wb_data), 32'h5A);
    chk("lat_wb_dest", 32'(wb_dest), 32'd3);
    step();
    chk("ret1_carry", 32'(carry_flag), 32'd1);
    chk("ret1_zero", 32'(zero_flag), 32'd0);
    chk("ret1_count", 32'(count), 32'd0);

    // Fill under stall, rejected push, release while full, then push+pop together
    wb_ready = 1'b0;
    drive(8'h11, 3'd1, 1'b1, 1'b0, 1'b0);
    step();
    drive(8'h22, 3'd2, 1'b1, 1'b0, 1'b1);
    step();
    chk("full_count", 32'(count), 32'd2);
    chk("full_res_ready", 32'(res_ready), 32'd0);
    drive(8'h33, 3'd3, 1'b1, 1'b1, 1'b1);
    step();
    chk("full_hold_count", 32'(count), 32'd2);
    chk("full_hold_data", 32'(wb_data), 32'h11);
    wb_ready = 1'b1;
    #1;
    chk("full_ready_indep", 32'(res_ready), 32'd0);
    step();
    chk("pop1_count", 32'(count), 32'd1);
    chk("pop1_data", 32'(wb_data), 32'h22);
    chk("pop1_res_ready", 32'(res_ready), 32'd1);
    step();
    chk("pushpop_count", 32'(count), 32'd1);
    chk("pushpop_data", 32'(wb_data), 32'h33);
    res_valid = 1'b0;
    step();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_carry", 32'(carry_flag), 32'd1);
    chk("drain_zero", 32'(zero_flag), 32'd1);

    // Forwarding picks the youngest matching entry
    wb_ready = 1'b0;
    drive(8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
    step();
    drive(8'h20, 3'd4, 1'b1, 1'b0, 1'b0);
    step();
    res_valid = 1'b0;
    fwd_addr1 = 3'd4; fwd_addr2 = 3'd5;
    #1;
    chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
    chk("fwd_data1", 32'(fwd_data1), 32'h20);
    chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
    chk("fwd_data2", 32'(fwd_data2), 32'd0);
    wb_ready = 1'b1;
    step();
    chk("fwd_after_pop_hit", 32'(fwd_hit1), 32'd1);
    chk("fwd_after_pop_data", 32'(fwd_data1), 32'h20);
    step();
    chk("fwd_empty_hit", 32'(fwd_hit1), 32'd0);
    chk("fwd_empty_data", 32'(fwd_data1), 32'd0);

    // Flags-only entry: no forward hit, retires with wen=0, updates zero
    wb_ready = 1'b0;
    drive(8'h99, 3'd6, 1'b0, 1'b0, 1'b1);
    step();
    res_valid = 1'b0;
    fwd_addr1 = 3'd6;
    #1;
    chk("flg_fwd_hit", 32'(fwd_hit1), 32'd0);
    chk("flg_wb_wen", 32'(wb_wen), 32'd0);
    chk("flg_wb_valid", 32'(wb_valid), 32'd1);
    wb_ready = 1'b1;
    step();
    chk("flg_zero", 32'(zero_flag), 32'd1);
    chk("flg_carry", 32'(carry_flag), 32'd0);

    // Asynchronous reset mid-operation discards queued entries
    wb_ready = 1'b0;
    drive(8'hA1, 3'd1, 1'b1, 1'b1, 1'b0);
    step();
    drive(8'hA2, 3'd2, 1'b1, 1'b1, 1'b0);
    step();
    res_valid = 1'b0;
    chk("prerst_count", 32'(count), 32'd2);
    #2 reset = 1'b1;
    sb.delete();
    m_carry = 1'b0; m_zero = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    chk("arst_res_ready", 32'(res_ready), 32'd1);
    chk("arst_zero", 32'(zero_flag), 32'd0);
    #2 reset = 1'b0;
    step();
    wb_ready = 1'b1;
    drive(8'h77, 3'd7, 1'b1, 1'b0, 1'b0);
    step();
    res_valid = 1'b0;
    chk("post_rst_data", 32'(wb_data), 32'h77);
    chk("post_rst_dest", 32'(wb_dest), 32'd7);
    step();
    chk("post_rst_count", 32'(count), 32'd0);

    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("retired_total", 32'(retired), 32'd8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
